// File: rtl/ram_dp_pkg.sv
// Shared defaults for the single-port-address dual-enable RAM (ram_dp).
// Width and depth defaults live here so the top and storage agree.
package ram_dp_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 10;
  localparam int DEPTH_DEF  = 2 ** ADDR_W_DEF;
endpackage

// File: rtl/ram_dp_mem.sv
// Word storage for ram_dp: zero-initialised array with one write port and
// an unregistered read port; the read register lives in the top level.
module ram_dp_mem #(
  parameter int WORD_W = 8,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  // Contents survive reset; only power-up clears them.
  logic [WORD_W-1:0] r_mem [DEPTH] = '{default: '0};

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ram_dp.sv
// Shared-address RAM with write-first registered read and async reset of dout.
// Optional even-parity storage and checking when RAM_DP_PARITY_EN is defined.
module ram_dp
  import ram_dp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] add,
  input  logic [DATA_W-1:0] din,
`ifdef RAM_DP_PARITY_EN
  output logic [DATA_W-1:0] dout,
  output logic              parity_err
`else
  output logic [DATA_W-1:0] dout
`endif
);

`ifdef RAM_DP_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int WORD_W = DATA_W + PAR_W;

  logic              w_in_range;
  logic              w_we;
  logic [WORD_W-1:0] w_wword;
  logic [WORD_W-1:0] w_rword;
  logic [DATA_W-1:0] r_dout;

  // Addresses past DEPTH neither write nor return stored data.
  assign w_in_range = ({1'b0, add} < (ADDR_W + 1)'(DEPTH));
  assign w_we       = wr & ~rst & w_in_range;

`ifdef RAM_DP_PARITY_EN
  assign w_wword = {^din, din};
`else
  assign w_wword = din;
`endif

  ram_dp_mem #(
    .WORD_W (WORD_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_addr  (add),
    .i_wdata (w_wword),
    .o_rdata (w_rword)
  );

  // Each enabled edge is one complete operation; there is no handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout <= '0;
    end else if (rd) begin
      if (!w_in_range) begin
        r_dout <= '0;
      end else if (wr) begin
        r_dout <= din;
      end else begin
        r_dout <= w_rword[DATA_W-1:0];
      end
    end
  end

  assign dout = r_dout;

`ifdef RAM_DP_PARITY_EN
  logic r_parity_err;

  // Write-first reads forward din, whose parity is correct by construction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parity_err <= 1'b0;
    end else if (rd) begin
      r_parity_err <= w_in_range & ~wr & (^w_rword);
    end
  end

  assign parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_ram_dp.sv
// Directed bench for ram_dp: writes, reads, hold, write-first, reset, boundaries.
// Parity checks are compiled in when RAM_DP_PARITY_EN is defined.
module tb_ram_dp;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr  = 1'b0;
  logic              rd  = 1'b0;
  logic [ADDR_W-1:0] add = '0;
  logic [DATA_W-1:0] din = '0;
  logic [DATA_W-1:0] dout;
`ifdef RAM_DP_PARITY_EN
  logic              parity_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_dp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .wr         (wr),
    .rd         (rd),
    .add        (add),
    .din        (din),
`ifdef RAM_DP_PARITY_EN
    .dout       (dout),
    .parity_err (parity_err)
`else
    .dout       (dout)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one operation and return #1 after the edge that performs it.
  task automatic op(input logic w, input logic r, input logic [ADDR_W-1:0] a,
                    input logic [DATA_W-1:0] d);
    @(negedge clk);
    wr = w; rd = r; add = a; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
  endtask

  initial begin
    // Reset state
    #1;
    check("reset_dout", 32'(dout), 32'h0);
`ifdef RAM_DP_PARITY_EN
    check("reset_parity_err", 32'(parity_err), 32'h0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Unwritten words and the top address
    op(1'b0, 1'b1, 10'd0, 8'h00);
    check("unwritten_addr0", 32'(dout), 32'h00);
    op(1'b0, 1'b1, 10'd1023, 8'h00);
    check("unwritten_addr1023", 32'(dout), 32'h00);

    // Sequential writes must not disturb dout
    op(1'b1, 1'b0, 10'd9, 8'hB9);
    op(1'b1, 1'b0, 10'd8, 8'h49);
    op(1'b1, 1'b0, 10'd7, 8'h0F);
    op(1'b1, 1'b0, 10'd6, 8'h98);
    op(1'b1, 1'b0, 10'd5, 8'h88);
    check("dout_after_writes", 32'(dout), 32'h00);

    // Read data is not visible before the edge
    @(negedge clk);
    wr = 1'b0; rd = 1'b1; add = 10'd9;
    #1;
    check("read_before_edge", 32'(dout), 32'h00);
    @(posedge clk);
    #1;
    check("read_9", 32'(dout), 32'hB9);
    op(1'b0, 1'b1, 10'd8, 8'h00);
    check("read_8", 32'(dout), 32'h49);
    op(1'b0, 1'b1, 10'd7, 8'h00);
    check("read_7", 32'(dout), 32'h0F);
    op(1'b0, 1'b1, 10'd6, 8'h00);
    check("read_6", 32'(dout), 32'h98);
    op(1'b0, 1'b1, 10'd5, 8'h00);
    check("read_5", 32'(dout), 32'h88);

    // Hold while writing with rd low
    op(1'b1, 1'b0, 10'd5, 8'h11);
    check("hold_during_write", 32'(dout), 32'h88);
    idle();
    @(posedge clk);
    #1;
    check("hold_idle", 32'(dout), 32'h88);
    op(1'b0, 1'b1, 10'd5, 8'h00);
    check("read_5_new", 32'(dout), 32'h11);

    // Same-edge write and read is write-first
    op(1'b1, 1'b1, 10'd3, 8'h5A);
    check("write_first", 32'(dout), 32'h5A);
    op(1'b0, 1'b1, 10'd7, 8'h00);
    check("read_7_again", 32'(dout), 32'h0F);
    op(1'b0, 1'b1, 10'd3, 8'h00);
    check("read_3", 32'(dout), 32'h5A);

    // Mid-cycle reset with an attempted overwrite while held
    op(1'b0, 1'b1, 10'd9, 8'h00);
    check("pre_reset_read_9", 32'(dout), 32'hB9);
    @(negedge clk);
    wr = 1'b1; rd = 1'b1; add = 10'd9; din = 8'h00;
    #2;
    rst = 1'b1;
    #1;
    check("reset_async_dout", 32'(dout), 32'h00);
    @(posedge clk);
    #1;
    check("reset_suppresses_read", 32'(dout), 32'h00);
    @(negedge clk);
    rst = 1'b0; wr = 1'b0; rd = 1'b0;
    op(1'b0, 1'b1, 10'd9, 8'h00);
    check("post_reset_read_9", 32'(dout), 32'hB9);

    // Boundary word
    op(1'b1, 1'b0, 10'd1023, 8'hFF);
    op(1'b0, 1'b1, 10'd1023, 8'h00);
    check("read_1023", 32'(dout), 32'hFF);

`ifdef RAM_DP_PARITY_EN
    op(1'b1, 1'b0, 10'd9, 8'hB9);
    op(1'b0, 1'b1, 10'd9, 8'h00);
    check("parity_ok_dout", 32'(dout), 32'hB9);
    check("parity_ok", 32'(parity_err), 32'h0);
    idle();
    u_dut.u_mem.r_mem[9] = u_dut.u_mem.r_mem[9] ^ 9'h001;
    op(1'b0, 1'b1, 10'd9, 8'h00);
    check("parity_bad_dout", 32'(dout), 32'hB8);
    check("parity_bad", 32'(parity_err), 32'h1);
    idle();
    @(posedge clk);
    #1;
    check("parity_hold", 32'(parity_err), 32'h1);
    op(1'b0, 1'b1, 10'd8, 8'h00);
    check("parity_clear", 32'(parity_err), 32'h0);
`endif

    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_dp.md
RAM_DP -- requirements
Module: ram_dp

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 10, address width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 2**ADDR_W (1024), number of words.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port wr, input, 1 bit: write enable.
REQ-007 The block SHALL have port rd, input, 1 bit: read enable.
REQ-008 The block SHALL have port add, input, ADDR_W bits: the shared read/write word address.
REQ-009 The block SHALL have port din, input, DATA_W bits: write data.
REQ-010 The block SHALL have port dout, output, DATA_W bits: registered read data.
REQ-011 The block SHALL have port parity_err, output, 1 bit, present only when RAM_DP_PARITY_EN is defined.

Function
REQ-012 A rising clk edge with wr=1 and rst=0 SHALL store din into mem[add].
REQ-013 A rising clk edge with rd=1 and rst=0 SHALL load dout with mem[add]; read latency is exactly one clock, so data is valid after that edge.
REQ-014 When wr=1 and rd=1 on the same edge, the read SHALL be write-first: dout takes din and mem[add] takes din.
REQ-015 When rd=0, dout SHALL hold its previous value, regardless of wr, add and din.
REQ-016 A write SHALL never change dout unless rd=1 on the same edge.
REQ-017 add values at or above DEPTH SHALL be ignored when DEPTH < 2**ADDR_W: no write occurs, and a read returns all zeros.
REQ-018 Words not yet written since power-up SHALL read as all zeros: the array is zero-initialised at time zero.
REQ-019 The block SHALL NOT buffer, retry or handshake: each enabled edge is one complete operation, with no back-pressure.

Reset
REQ-020 Asserting rst SHALL immediately, without waiting for clk, drive dout to 0 (and parity_err to 0 when present).
REQ-021 Reset SHALL NOT clear the memory array; contents written before reset SHALL remain readable after it.
REQ-022 While rst=1, writes and reads SHALL be suppressed.
REQ-023 After rst is deasserted, the first rising edge SHALL operate normally.

Configuration
REQ-024 With macro RAM_DP_PARITY_EN defined, each word SHALL store one extra even-parity bit, computed from din on write.
REQ-025 With RAM_DP_PARITY_EN defined, each read SHALL set parity_err in the same cycle as dout when the stored parity bit mismatches the stored data; otherwise parity_err SHALL be 0.
REQ-026 parity_err SHALL hold its value between reads.
REQ-027 Without RAM_DP_PARITY_EN, the block SHALL have no parity storage and no parity_err port; function is otherwise identical.

Structure
REQ-028 Shared package ram_dp_pkg SHALL hold the DATA_W and ADDR_W defaults and the DEPTH constant.
REQ-029 Storage SHALL sit in one sub-module, ram_dp_mem, holding the array and its write port.
REQ-030 The top level ram_dp SHALL contain the read register, reset and parity logic.

Verification
REQ-031 Sequential write: wr=1, rd=0 writing 0xB9->9, 0x49->8, 0x0F->7, 0x98->6, 0x88->5; then rd=1, wr=0 at addresses 9, 8, 7, 6, 5 -> dout = 0xB9, 0x49, 0x0F, 0x98, 0x88, each one edge after its read.
REQ-032 Hold: after reading 0x88 from address 5, set rd=0, wr=1 and write 0x11->5 -> dout stays 0x88 until the next read, which returns 0x11.
REQ-033 Same-edge write and read: wr=1, rd=1, add=3, din=0x5A -> dout = 0x5A after that edge; a later read of 3 returns 0x5A.
REQ-034 Mid-operation reset: assert rst between clock edges while dout=0xB9 -> dout = 0 immediately; after release, reading address 9 returns 0xB9.
REQ-035 Unwritten and boundary words: read address 0 and address 1023 before any write -> dout = 0x00; write 0xFF->1023 and read it back -> 0xFF.
REQ-036 Parity (RAM_DP_PARITY_EN defined): write 0xB9->9 and read it -> parity_err = 0; force-flip one stored data bit of word 9 and read again -> parity_err = 1.
